// File: rtl/digit_scanner_pkg.sv
// Shared types and helpers for the digit scan controller: FSM state encoding,
// digit code width and the one-hot enable builder.
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam int DIGIT_W    = 2;
    localparam int MAX_DIGITS = 32;

    // Callers truncate the result to their own NUM_DIGITS width.
    function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        if (idx < MAX_DIGITS) begin
            v[idx[$clog2(MAX_DIGITS)-1:0]] = 1'b1;
        end else begin
            v = '0;
        end
        return v;
    endfunction

endpackage

// File: rtl/digit_scanner_if.sv
// Host-side bundle of the scan controller: run/load controls in, display drive
// and status pulses out.
interface digit_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    import scan_pkg::*;

    logic                          enable;
    logic                          load;
    logic [DIGIT_W*NUM_DIGITS-1:0] load_data;
    logic                          load_ack;
    logic [DIGIT_W-1:0]            bin;
    logic [NUM_DIGITS-1:0]         digit_en;
    logic                          frame_done;

    modport master (
        output enable, load, load_data,
        input  load_ack, bin, digit_en, frame_done
    );

    modport slave (
        input  enable, load, load_data,
        output load_ack, bin, digit_en, frame_done
    );

endinterface

// File: rtl/digit_scanner_slot_timer.sv
// Slot timer: counts up from zero while running and raises tc_o on the
// programmed last count, wrapping back to zero by explicit compare.
module slot_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic [CNT_W-1:0] last_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    assign tc_o = (count_q == last_i);

    // Next count: idle clears, terminal count wraps, otherwise increment
    always_comb begin
        count_d = count_q;
        if (!run_i) begin
            count_d = '0;
        end else if (tc_o) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/digit_scanner.sv
// Scan controller: multiplexes NUM_DIGITS 2-bit codes onto one bin bus with a
// blanking gap between digits; new frame data is swapped in only at frame edges.
module digit_scanner
    import scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    digit_scanner_if.slave bus
);

    localparam int SPAN  = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CNT_W = $clog2(SPAN);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] frame_t;

    scan_state_t           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    frame_t                active_q, active_d, shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [DIGIT_W-1:0]    bin_q, bin_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
    logic                  load_ack_q, load_ack_d;
    logic                  frame_done_q, frame_done_d;
    logic                  run_s, tc_s, boundary_s;
    logic [CNT_W-1:0]      last_s;

    assign run_s      = bus.enable && (state_q != IDLE);
    assign boundary_s = bus.enable && (state_q == BLANK) && tc_s && (idx_q == LAST_IDX);

    // One timer serves both slot phases; only its terminal value changes
    always_comb begin
        last_s = SHOW_LAST;
        if (state_q == BLANK) begin
            last_s = BLANK_LAST;
        end else begin
            last_s = SHOW_LAST;
        end
    end

    slot_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run_i  (run_s),
        .last_i (last_s),
        .tc_o   (tc_s)
    );

    // Next-state logic: dropping enable always returns to IDLE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (!bus.enable) begin
            state_d = IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = SHOW;
                    idx_d   = '0;
                end
                SHOW: begin
                    state_d = tc_s ? BLANK : SHOW;
                end
                BLANK: begin
                    if (tc_s) begin
                        state_d = SHOW;
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        state_d = BLANK;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Frame data: IDLE applies loads at once, otherwise they wait for a frame edge
    always_comb begin
        active_d   = active_q;
        shadow_d   = shadow_q;
        pending_d  = pending_q;
        load_ack_d = 1'b0;
        if (state_q == IDLE) begin
            if (bus.load) begin
                active_d   = bus.load_data;
                shadow_d   = bus.load_data;
                pending_d  = 1'b0;
                load_ack_d = 1'b1;
            end else if (pending_q) begin
                active_d   = shadow_q;
                pending_d  = 1'b0;
                load_ack_d = 1'b1;
            end else begin
                load_ack_d = 1'b0;
            end
        end else if (boundary_s && pending_q) begin
            active_d   = shadow_q;
            load_ack_d = 1'b1;
            pending_d  = bus.load;
            shadow_d   = bus.load ? frame_t'(bus.load_data) : shadow_q;
        end else if (bus.load) begin
            shadow_d  = bus.load_data;
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end
    end

    // Output logic from the next state so the registered outputs line up with it
    always_comb begin
        digit_en_d   = '0;
        bin_d        = bin_q;
        frame_done_d = boundary_s;
        if (state_d == SHOW) begin
            digit_en_d = NUM_DIGITS'(onehot(32'(idx_d)));
            bin_d      = active_d[idx_d];
        end else begin
            digit_en_d = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            bin_q        <= '0;
            digit_en_q   <= '0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            bin_q        <= bin_d;
            digit_en_q   <= digit_en_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Frame data registers; reset discards anything still pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    assign bus.bin        = bin_q;
    assign bus.digit_en   = digit_en_q;
    assign bus.load_ack   = load_ack_q;
    assign bus.frame_done = frame_done_q;

endmodule
